reorder_buffer_mc: RTL and testbench

- Parametrised, multi-commit reorder buffer for the out-of-order core.
- Allocates entries in program order from the decoder and accepts results from NUM_WB writeback channels (ALU, LSB, …).
- Retires up to COMMIT_W consecutive ready entries per cycle to the register file, LSB store queue and branch predictor.
- Raises a one-cycle flush with a redirect PC on a branch mispredict or JALR.

---
 rtl/reorder_buffer_mc_pkg.sv | 32 +++
 rtl/reorder_buffer_mc_commit_select.sv | 72 +++++++
 rtl/reorder_buffer_mc.sv | 233 +++++++++++++++++++++++
 tb/tb_reorder_buffer_mc.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reorder_buffer_mc_pkg.sv
// Shared op-class codes, default widths and small decode helpers for the
// multi-commit reorder buffer.
package reorder_buffer_mc_pkg;

  localparam int OP_W      = 2;
  localparam int XLEN_DEF  = 32;
  localparam int REG_W_DEF = 5;

  typedef enum logic [OP_W-1:0] {
    OP_OTHER = 2'd0,
    OP_BR    = 2'd1,
    OP_JALR  = 2'd2,
    OP_STORE = 2'd3
  } op_e;

  // Control-flow entries share one retirement slot per cycle.
  function automatic logic is_ctrl(input logic [OP_W-1:0] op);
    return (op == OP_BR) || (op == OP_JALR);
  endfunction

  // JALR targets are never predicted, so every JALR redirects fetch.
  function automatic logic is_mispredict(input logic [OP_W-1:0] op,
                                         input logic            pred_taken,
                                         input logic            taken);
    case (op)
      OP_BR:   return pred_taken != taken;
      OP_JALR: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/reorder_buffer_mc_commit_select.sv
// Combinational retirement scan: picks the longest retirable prefix starting
// at head and reports whether it ends on a mispredict (with restart PC).
module rob_commit_select
  import reorder_buffer_mc_pkg::*;
#(
  parameter int COMMIT_W = 2,
  parameter int XLEN     = XLEN_DEF,
  parameter int CNT_W    = $clog2(COMMIT_W + 1)
) (
  input  logic [COMMIT_W-1:0]      slot_ok,
  input  logic [COMMIT_W*OP_W-1:0] slot_op,
  input  logic [COMMIT_W-1:0]      slot_pred_taken,
  input  logic [COMMIT_W-1:0]      slot_taken,
  input  logic [COMMIT_W*XLEN-1:0] slot_pc,
  input  logic [COMMIT_W*XLEN-1:0] slot_target,
  output logic [COMMIT_W-1:0]      commit_en,
  output logic [CNT_W-1:0]         commit_cnt,
  output logic                     mispredict,
  output logic [XLEN-1:0]          redirect
);

  logic            stop;
  logic            ctrl_seen;
  logic            store_seen;
  logic [OP_W-1:0] op_s;
  logic [XLEN-1:0] pc_s;
  logic [XLEN-1:0] tgt_s;

  // Prefix scan: a slot retires only if every older slot retired and it does
  // not add a second control-flow op or a second store to this cycle.
  always_comb begin
    commit_en  = '0;
    commit_cnt = '0;
    mispredict = 1'b0;
    redirect   = '0;
    stop       = 1'b0;
    ctrl_seen  = 1'b0;
    store_seen = 1'b0;
    op_s       = '0;
    pc_s       = '0;
    tgt_s      = '0;
    for (int s = 0; s < COMMIT_W; s++) begin
      op_s  = slot_op[s*OP_W +: OP_W];
      pc_s  = slot_pc[s*XLEN +: XLEN];
      tgt_s = slot_target[s*XLEN +: XLEN];
      if (!stop) begin
        if (!slot_ok[s]) begin
          stop = 1'b1;
        end else if (is_ctrl(op_s) && ctrl_seen) begin
          stop = 1'b1;
        end else if ((op_s == OP_STORE) && store_seen) begin
          stop = 1'b1;
        end else begin
          commit_en[s] = 1'b1;
          commit_cnt   = commit_cnt + CNT_W'(1);
          if (is_ctrl(op_s)) ctrl_seen = 1'b1;
          if (op_s == OP_STORE) store_seen = 1'b1;
          if (is_mispredict(op_s, slot_pred_taken[s], slot_taken[s])) begin
            mispredict = 1'b1;
            if ((op_s == OP_BR) && slot_pred_taken[s])
              redirect = pc_s + XLEN'(4);
            else
              redirect = tgt_s;
            // Younger entries sit on the wrong path; nothing past this retires.
            stop = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/reorder_buffer_mc.sv
// Multi-commit reorder buffer: in-order allocation, NUM_WB writeback ports,
// rename-tag lookup with writeback bypass, up to COMMIT_W retirements per
// cycle, and a registered flush/redirect on mispredicted control flow.
module reorder_buffer_mc
  import reorder_buffer_mc_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int IDX_W    = 4,
  parameter int NUM_WB   = 2,
  parameter int COMMIT_W = 2,
  parameter int XLEN     = XLEN_DEF,
  parameter int REG_W    = REG_W_DEF
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      issue_valid,
  input  logic [OP_W-1:0]           issue_op,
  input  logic [REG_W-1:0]          issue_rd,
  input  logic [XLEN-1:0]           issue_pc,
  input  logic                      issue_pred_taken,
  input  logic                      issue_ext_stall,
  output logic                      issue_accept,
  output logic [IDX_W-1:0]          issue_index,
  input  logic [NUM_WB-1:0]         wb_valid,
  input  logic [NUM_WB*IDX_W-1:0]   wb_index,
  input  logic [NUM_WB*XLEN-1:0]    wb_data,
  input  logic [NUM_WB-1:0]         wb_taken,
  input  logic [NUM_WB*XLEN-1:0]    wb_target,
  input  logic [2*IDX_W-1:0]        q_index,
  output logic [1:0]                q_ready,
  output logic [2*XLEN-1:0]         q_data,
  output logic [COMMIT_W-1:0]       commit_valid,
  output logic [COMMIT_W*REG_W-1:0] commit_rd,
  output logic [COMMIT_W*IDX_W-1:0] commit_index,
  output logic [COMMIT_W*XLEN-1:0]  commit_data,
  output logic                      store_commit_valid,
  output logic [IDX_W-1:0]          store_commit_index,
  output logic                      bp_valid,
  output logic [XLEN-1:0]           bp_pc,
  output logic                      bp_taken,
  output logic                      flush,
  output logic [XLEN-1:0]           redirect_pc,
  output logic [IDX_W:0]            count,
  output logic                      full,
  output logic                      empty
);

  localparam int CNT_W = $clog2(COMMIT_W + 1);

  logic [DEPTH-1:0] e_valid;
  logic [DEPTH-1:0] e_ready;
  logic [DEPTH-1:0] e_pred;
  logic [DEPTH-1:0] e_taken;
  logic [OP_W-1:0]  e_op     [DEPTH];
  logic [REG_W-1:0] e_rd     [DEPTH];
  logic [XLEN-1:0]  e_pc     [DEPTH];
  logic [XLEN-1:0]  e_data   [DEPTH];
  logic [XLEN-1:0]  e_target [DEPTH];

  logic [IDX_W-1:0] head;
  logic [IDX_W-1:0] tail;

  logic [IDX_W-1:0] wb_idx   [NUM_WB];
  logic [IDX_W-1:0] q_idx    [2];
  logic [IDX_W-1:0] slot_idx [COMMIT_W];

  logic [COMMIT_W-1:0]      slot_ok;
  logic [COMMIT_W*OP_W-1:0] slot_op;
  logic [COMMIT_W-1:0]      slot_pred;
  logic [COMMIT_W-1:0]      slot_taken;
  logic [COMMIT_W*XLEN-1:0] slot_pc;
  logic [COMMIT_W*XLEN-1:0] slot_target;

  logic [COMMIT_W-1:0] sel_en;
  logic [CNT_W-1:0]    sel_cnt;
  logic                sel_misp;
  logic [XLEN-1:0]     sel_redirect;

  assign full         = (count == (IDX_W+1)'(DEPTH));
  assign empty        = (count == '0);
  assign issue_index  = tail;
  assign issue_accept = issue_valid & ~full & ~issue_ext_stall & ~flush & rdy_in;

  // Unpack the flat writeback and lookup index buses.
  always_comb begin
    for (int c = 0; c < NUM_WB; c++) wb_idx[c] = wb_index[c*IDX_W +: IDX_W];
    for (int j = 0; j < 2; j++) q_idx[j] = q_index[j*IDX_W +: IDX_W];
  end

  // Operand lookup: stored result first, otherwise bypass a same-cycle
  // writeback; channels scanned high to low so channel 0 has the last word.
  always_comb begin
    q_ready = '0;
    q_data  = '0;
    for (int j = 0; j < 2; j++) begin
      if (e_ready[q_idx[j]]) begin
        q_ready[j]                = 1'b1;
        q_data[j*XLEN +: XLEN]    = e_data[q_idx[j]];
      end else begin
        for (int c = NUM_WB - 1; c >= 0; c--) begin
          if (wb_valid[c] && (wb_idx[c] == q_idx[j])) begin
            q_ready[j]             = 1'b1;
            q_data[j*XLEN +: XLEN] = wb_data[c*XLEN +: XLEN];
          end
        end
      end
    end
  end

  // Gather the COMMIT_W entries starting at head for the retirement scan.
  // During the flush cycle nothing is offered so nothing retires.
  always_comb begin
    slot_ok     = '0;
    slot_op     = '0;
    slot_pred   = '0;
    slot_taken  = '0;
    slot_pc     = '0;
    slot_target = '0;
    for (int s = 0; s < COMMIT_W; s++) begin
      slot_idx[s]                    = head + IDX_W'(s);
      slot_ok[s]                     = e_valid[slot_idx[s]] & e_ready[slot_idx[s]] & ~flush;
      slot_op[s*OP_W +: OP_W]        = e_op[slot_idx[s]];
      slot_pred[s]                   = e_pred[slot_idx[s]];
      slot_taken[s]                  = e_taken[slot_idx[s]];
      slot_pc[s*XLEN +: XLEN]        = e_pc[slot_idx[s]];
      slot_target[s*XLEN +: XLEN]    = e_target[slot_idx[s]];
    end
  end

  rob_commit_select #(
    .COMMIT_W (COMMIT_W),
    .XLEN     (XLEN),
    .CNT_W    (CNT_W)
  ) u_commit_select (
    .slot_ok         (slot_ok),
    .slot_op         (slot_op),
    .slot_pred_taken (slot_pred),
    .slot_taken      (slot_taken),
    .slot_pc         (slot_pc),
    .slot_target     (slot_target),
    .commit_en       (sel_en),
    .commit_cnt      (sel_cnt),
    .mispredict      (sel_misp),
    .redirect        (sel_redirect)
  );

  // Entry storage, queue pointers and registered retire/flush outputs.
  // While rdy_in is low a pending flush is held (it is state) and executes
  // once the core is enabled again; the retire pulses are forced low.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      e_valid            <= '0;
      e_ready            <= '0;
      head               <= '0;
      tail               <= '0;
      count              <= '0;
      commit_valid       <= '0;
      commit_rd          <= '0;
      commit_index       <= '0;
      commit_data        <= '0;
      store_commit_valid <= 1'b0;
      store_commit_index <= '0;
      bp_valid           <= 1'b0;
      bp_pc              <= '0;
      bp_taken           <= 1'b0;
      flush              <= 1'b0;
      redirect_pc        <= '0;
    end else begin
      commit_valid       <= '0;
      commit_rd          <= '0;
      commit_index       <= '0;
      commit_data        <= '0;
      store_commit_valid <= 1'b0;
      store_commit_index <= '0;
      bp_valid           <= 1'b0;
      bp_pc              <= '0;
      bp_taken           <= 1'b0;
      if (rdy_in) begin
        if (flush) begin
          e_valid <= '0;
          e_ready <= '0;
          head    <= '0;
          tail    <= '0;
          count   <= '0;
          flush   <= 1'b0;
        end else begin
          for (int c = NUM_WB - 1; c >= 0; c--) begin
            if (wb_valid[c] && e_valid[wb_idx[c]]) begin
              e_ready[wb_idx[c]]  <= 1'b1;
              e_data[wb_idx[c]]   <= wb_data[c*XLEN +: XLEN];
              e_taken[wb_idx[c]]  <= wb_taken[c];
              e_target[wb_idx[c]] <= wb_target[c*XLEN +: XLEN];
            end
          end
          for (int s = 0; s < COMMIT_W; s++) begin
            if (sel_en[s]) begin
              e_valid[slot_idx[s]]             <= 1'b0;
              e_ready[slot_idx[s]]             <= 1'b0;
              commit_valid[s]                  <= 1'b1;
              commit_rd[s*REG_W +: REG_W]      <= e_rd[slot_idx[s]];
              commit_index[s*IDX_W +: IDX_W]   <= slot_idx[s];
              commit_data[s*XLEN +: XLEN]      <= e_data[slot_idx[s]];
              if (e_op[slot_idx[s]] == OP_STORE) begin
                store_commit_valid <= 1'b1;
                store_commit_index <= slot_idx[s];
              end
              if (e_op[slot_idx[s]] == OP_BR) begin
                bp_valid <= 1'b1;
                bp_pc    <= e_pc[slot_idx[s]];
                bp_taken <= e_taken[slot_idx[s]];
              end
            end
          end
          if (issue_accept) begin
            e_valid[tail] <= 1'b1;
            e_ready[tail] <= 1'b0;
            e_op[tail]    <= issue_op;
            e_rd[tail]    <= issue_rd;
            e_pc[tail]    <= issue_pc;
            e_pred[tail]  <= issue_pred_taken;
          end
          head  <= head + IDX_W'(sel_cnt);
          tail  <= tail + IDX_W'(issue_accept);
          count <= count + (IDX_W+1)'(issue_accept) - (IDX_W+1)'(sel_cnt);
          flush <= sel_misp;
          if (sel_misp) redirect_pc <= sel_redirect;
        end
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer_mc.sv
module tb_reorder_buffer_mc;
  import reorder_buffer_mc_pkg::*;

  localparam int DEPTH = 16, IDX_W = 4, NUM_WB = 2, COMMIT_W = 2, XLEN = 32, REG_W = 5;

  logic                      clk_in = 1'b0;
  logic                      rst_in, rdy_in;
  logic                      issue_valid, issue_pred_taken, issue_ext_stall;
  logic [OP_W-1:0]           issue_op;
  logic [REG_W-1:0]          issue_rd;
  logic [XLEN-1:0]           issue_pc;
  logic                      issue_accept;
  logic [IDX_W-1:0]          issue_index;
  logic [NUM_WB-1:0]         wb_valid, wb_taken;
  logic [NUM_WB*IDX_W-1:0]   wb_index;
  logic [NUM_WB*XLEN-1:0]    wb_data, wb_target;
  logic [2*IDX_W-1:0]        q_index;
  logic [1:0]                q_ready;
  logic [2*XLEN-1:0]         q_data;
  logic [COMMIT_W-1:0]       commit_valid;
  logic [COMMIT_W*REG_W-1:0] commit_rd;
  logic [COMMIT_W*IDX_W-1:0] commit_index;
  logic [COMMIT_W*XLEN-1:0]  commit_data;
  logic                      store_commit_valid, bp_valid, bp_taken, flush, full, empty;
  logic [IDX_W-1:0]          store_commit_index;
  logic [XLEN-1:0]           bp_pc, redirect_pc;
  logic [IDX_W:0]            count;

  int n_cmp = 0;
  int n_err = 0;
  int exp_next = 0;
  logic mon_en = 1'b0;

  reorder_buffer_mc #(
    .DEPTH(DEPTH), .IDX_W(IDX_W), .NUM_WB(NUM_WB),
    .COMMIT_W(COMMIT_W), .XLEN(XLEN), .REG_W(REG_W)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .issue_valid(issue_valid), .issue_op(issue_op), .issue_rd(issue_rd),
    .issue_pc(issue_pc), .issue_pred_taken(issue_pred_taken),
    .issue_ext_stall(issue_ext_stall), .issue_accept(issue_accept),
    .issue_index(issue_index), .wb_valid(wb_valid), .wb_index(wb_index),
    .wb_data(wb_data), .wb_taken(wb_taken), .wb_target(wb_target),
    .q_index(q_index), .q_ready(q_ready), .q_data(q_data),
    .commit_valid(commit_valid), .commit_rd(commit_rd),
    .commit_index(commit_index), .commit_data(commit_data),
    .store_commit_valid(store_commit_valid), .store_commit_index(store_commit_index),
    .bp_valid(bp_valid), .bp_pc(bp_pc), .bp_taken(bp_taken),
    .flush(flush), .redirect_pc(redirect_pc),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; optionally check retirements against the in-order
  // sequence used by the wrap-around run (instruction n carries data n).
  task automatic tick();
    @(posedge clk_in);
    #1;
    if (mon_en) begin
      for (int s = 0; s < COMMIT_W; s++) begin
        if (commit_valid[s]) begin
          chk("wrap_index", 64'(commit_index[s*IDX_W +: IDX_W]), 64'(exp_next % DEPTH));
          chk("wrap_data", 64'(commit_data[s*XLEN +: XLEN]), 64'(exp_next));
          exp_next++;
        end
      end
    end
  endtask

  task automatic idle();
    issue_valid = 1'b0; issue_op = OP_OTHER; issue_rd = '0; issue_pc = '0;
    issue_pred_taken = 1'b0; issue_ext_stall = 1'b0;
    wb_valid = '0; wb_index = '0; wb_data = '0; wb_taken = '0; wb_target = '0;
  endtask

  task automatic do_issue(input logic [OP_W-1:0] op, input int rd, input logic [31:0] pc,
                          input logic pred);
    issue_valid = 1'b1; issue_op = op; issue_rd = 5'(rd); issue_pc = pc;
    issue_pred_taken = pred;
  endtask

  task automatic set_wb(input int ch, input int idx, input logic [31:0] data,
                        input logic taken, input logic [31:0] tgt);
    wb_valid[ch] = 1'b1;
    wb_index[ch*IDX_W +: IDX_W] = 4'(idx);
    wb_data[ch*XLEN +: XLEN] = data;
    wb_taken[ch] = taken;
    wb_target[ch*XLEN +: XLEN] = tgt;
  endtask

  task automatic do_reset();
    rst_in = 1'b0;
    tick();
    rst_in = 1'b1;
  endtask

  // A writeback must never target the entry being allocated in the same cycle.
  always @(negedge clk_in) begin
    for (int c = 0; c < NUM_WB; c++) begin
      if (rst_in && issue_accept && wb_valid[c] && (wb_index[c*IDX_W +: IDX_W] == issue_index)) begin
        n_err++;
        $error("FAIL wb_alloc_clash: channel %0d index %0h", c, issue_index);
      end
    end
  end

  initial begin
    idle();
    q_index = '0;
    rdy_in  = 1'b1;
    rst_in  = 1'b0;
    tick();
    do_reset();

    // Reset state
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_commit_valid", 64'(commit_valid), 64'd0);
    chk("rst_flush", 64'(flush), 64'd0);

    // Fill all 16 entries, then the 17th is refused
    for (int i = 0; i < DEPTH; i++) begin
      do_issue(OP_OTHER, i + 1, 32'h100 + 32'(4 * i), 1'b0);
      #1;
      chk("fill_accept", 64'(issue_accept), 64'd1);
      chk("fill_index", 64'(issue_index), 64'(i));
      tick();
    end
    do_issue(OP_OTHER, 17, 32'h200, 1'b0);
    #1;
    chk("full_count", 64'(count), 64'd16);
    chk("full_flag", 64'(full), 64'd1);
    chk("full_accept", 64'(issue_accept), 64'd0);
    idle();

    // Two-channel writeback of entries 0 and 1, with lookup bypass
    set_wb(0, 0, 32'hA0, 1'b0, 32'h0);
    set_wb(1, 1, 32'hA1, 1'b0, 32'h0);
    q_index = {4'd1, 4'd0};
    #1;
    chk("bypass_ready", 64'(q_ready), 64'h3);
    chk("bypass_data", 64'(q_data), 64'h000000A1_000000A0);
    tick();
    idle();
    tick();
    chk("dual_commit_valid", 64'(commit_valid), 64'h3);
    chk("dual_commit_index", 64'(commit_index), 64'h10);
    chk("dual_commit_data", 64'(commit_data), 64'h000000A1_000000A0);
    chk("dual_commit_rd", 64'(commit_rd), 64'({5'd2, 5'd1}));
    chk("dual_count", 64'(count), 64'd14);
    chk("dual_tail", 64'(issue_index), 64'd0);
    tick();
    chk("dual_after_valid", 64'(commit_valid), 64'd0);

    // Branch mispredict at head, younger ready entry must not retire
    do_reset();
    do_issue(OP_BR, 0, 32'h200, 1'b0);  tick();
    do_issue(OP_OTHER, 7, 32'h204, 1'b0); tick();
    do_issue(OP_OTHER, 8, 32'h208, 1'b0); tick();
    idle();
    set_wb(0, 0, 32'h0, 1'b1, 32'h1000);
    set_wb(1, 1, 32'h55, 1'b0, 32'h0);
    tick();
    idle();
    tick();
    chk("br_commit_valid", 64'(commit_valid), 64'h1);
    chk("br_commit_index", 64'(commit_index), 64'h0);
    chk("br_bp_valid", 64'(bp_valid), 64'd1);
    chk("br_bp_pc", 64'(bp_pc), 64'h200);
    chk("br_bp_taken", 64'(bp_taken), 64'd1);
    chk("br_flush", 64'(flush), 64'd1);
    chk("br_redirect", 64'(redirect_pc), 64'h1000);
    chk("br_count", 64'(count), 64'd2);
    do_issue(OP_OTHER, 9, 32'h20C, 1'b0);
    #1;
    chk("flush_blocks_issue", 64'(issue_accept), 64'd0);
    tick();
    idle();
    chk("post_flush_flag", 64'(flush), 64'd0);
    chk("post_flush_count", 64'(count), 64'd0);
    chk("post_flush_empty", 64'(empty), 64'd1);
    chk("post_flush_commit", 64'(commit_valid), 64'd0);

    // JALR always redirects to its target and does not update the predictor
    do_issue(OP_JALR, 1, 32'h300, 1'b1); tick();
    idle();
    set_wb(0, 0, 32'h304, 1'b1, 32'h2222);
    tick();
    idle();
    tick();
    chk("jalr_flush", 64'(flush), 64'd1);
    chk("jalr_redirect", 64'(redirect_pc), 64'h2222);
    chk("jalr_bp_valid", 64'(bp_valid), 64'd0);
    tick();

    // Two adjacent stores retire one per cycle
    do_issue(OP_STORE, 0, 32'h400, 1'b0); tick();
    do_issue(OP_STORE, 0, 32'h404, 1'b0); tick();
    idle();
    set_wb(0, 0, 32'h0, 1'b0, 32'h0);
    set_wb(1, 1, 32'h0, 1'b0, 32'h0);
    tick();
    idle();
    tick();
    chk("st1_valid", 64'(store_commit_valid), 64'd1);
    chk("st1_index", 64'(store_commit_index), 64'd0);
    chk("st1_commit", 64'(commit_valid), 64'h1);
    tick();
    chk("st2_valid", 64'(store_commit_valid), 64'd1);
    chk("st2_index", 64'(store_commit_index), 64'd1);
    tick();
    chk("st3_valid", 64'(store_commit_valid), 64'd0);
    chk("st3_count", 64'(count), 64'd0);

    // Same-index writeback on both channels: channel 0 wins, bypass agrees
    do_reset();
    for (int i = 0; i < 4; i++) begin
      do_issue(OP_OTHER, i + 1, 32'h500 + 32'(4 * i), 1'b0);
      tick();
    end
    idle();
    set_wb(0, 3, 32'hAA, 1'b0, 32'h0);
    set_wb(1, 3, 32'hBB, 1'b0, 32'h0);
    q_index = {4'd2, 4'd3};
    #1;
    chk("samewb_q_ready", 64'(q_ready), 64'h1);
    chk("samewb_q_data", 64'(q_data[31:0]), 64'hAA);
    tick();
    idle();
    #1;
    chk("stored_q_ready", 64'(q_ready), 64'h1);
    chk("stored_q_data", 64'(q_data[31:0]), 64'hAA);
    chk("samewb_count", 64'(count), 64'd4);

    // rdy_in low freezes everything
    do_reset();
    do_issue(OP_OTHER, 1, 32'h600, 1'b0); tick();
    do_issue(OP_OTHER, 2, 32'h604, 1'b0); tick();
    idle();
    set_wb(0, 0, 32'h11, 1'b0, 32'h0);
    set_wb(1, 1, 32'h22, 1'b0, 32'h0);
    tick();
    idle();
    rdy_in = 1'b0;
    do_issue(OP_OTHER, 3, 32'h608, 1'b0);
    #1;
    chk("frozen_accept", 64'(issue_accept), 64'd0);
    tick();
    chk("frozen_commit", 64'(commit_valid), 64'd0);
    chk("frozen_count", 64'(count), 64'd2);
    idle();
    rdy_in = 1'b1;
    tick();
    chk("thaw_commit", 64'(commit_valid), 64'h3);
    chk("thaw_count", 64'(count), 64'd0);

    // Steady-state stream of 40 instructions wrapping the index space
    do_reset();
    exp_next = 0;
    mon_en = 1'b1;
    for (int c = 0; c <= 40; c++) begin
      idle();
      if (c < 40) do_issue(OP_OTHER, (c % 31) + 1, 32'h1000 + 32'(4 * c), 1'b0);
      if (c >= 1) set_wb(0, (c - 1) % DEPTH, 32'(c - 1), 1'b0, 32'h0);
      tick();
    end
    idle();
    for (int d = 0; d < 4; d++) tick();
    mon_en = 1'b0;
    chk("wrap_total", 64'(exp_next), 64'd40);
    chk("wrap_count", 64'(count), 64'd0);

    // Reset mid-run suppresses a pending retirement
    do_issue(OP_OTHER, 4, 32'h700, 1'b0); tick();
    do_issue(OP_OTHER, 5, 32'h704, 1'b0); tick();
    idle();
    set_wb(0, 8, 32'h33, 1'b0, 32'h0);
    set_wb(1, 9, 32'h44, 1'b0, 32'h0);
    tick();
    idle();
    rst_in = 1'b0;
    tick();
    chk("midrst_commit", 64'(commit_valid), 64'd0);
    chk("midrst_count", 64'(count), 64'd0);
    chk("midrst_empty", 64'(empty), 64'd1);
    chk("midrst_flush", 64'(flush), 64'd0);
    chk("midrst_store", 64'(store_commit_valid), 64'd0);
    chk("midrst_bp", 64'(bp_valid), 64'd0);
    rst_in = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
